// File: rtl/act_lut_pkg.sv
// Shared constants and types for the writable activation LUT and its loader.
package act_lut_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int ENTRIES    = (2 ** ADDR_WIDTH) + 1;

  // Load controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Write index: one bit wider than the segment address so it can reach
  // breakpoint 16 (the right endpoint of the last segment).
  typedef logic [ADDR_WIDTH:0] idx_t;

endpackage : act_lut_pkg

// File: rtl/act_lut_regfile.sv
// Breakpoint storage: ENTRIES x DW registers, one synchronous write port,
// two combinational read ports returning entry[addr] and entry[addr+1].
module act_lut_regfile #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int N  = (2 ** AW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW:0]   wr_index,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_address,
  output logic [DW-1:0] rd_base,
  output logic [DW-1:0] rd_next_data
);

  localparam int IW = AW + 1;

  logic [DW-1:0] entry [N];
  logic [IW-1:0] rd_index;
  logic [IW-1:0] rd_index_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      logic [DW-1:0] entry_reg;

      // Each breakpoint captures wr_data when the write index selects it.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_index == IW'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entry[gi] = entry_reg;
    end
  endgenerate

  // The upper neighbour index is formed one bit wider so address 15 reaches
  // entry 16 instead of wrapping to entry 0.
  assign rd_index      = {1'b0, rd_address};
  assign rd_index_next = rd_index + IW'(1);

  assign rd_base      = entry[rd_index];
  assign rd_next_data = entry[rd_index_next];

endmodule : act_lut_regfile

// File: rtl/act_lut_loader.sv
// Load controller for the activation LUT: accepts exactly ENTRIES breakpoints
// over a valid/ready handshake and exposes the table once a load completes.
module act_lut_loader
  import act_lut_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  busy,
  output logic                  load_done,
  output logic                  table_valid,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] rd_base,
  output logic [DATA_WIDTH-1:0] rd_next_data
);

  localparam idx_t LAST_INDEX = idx_t'(ENTRIES - 1);

  state_t state_reg;
  idx_t   idx_reg;
  logic   load_done_reg;
  logic   table_valid_reg;
  logic   wr_en;

  logic [DATA_WIDTH-1:0] raw_base;
  logic [DATA_WIDTH-1:0] raw_next;

  // Handshake and busy flags follow the state register directly.
  assign wr_ready = (state_reg == LOAD);
  assign busy     = (state_reg != IDLE);
  assign wr_en    = wr_ready && wr_valid;

  // Load sequencing: start, count accepted breakpoints, one-cycle DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      load_done_reg   <= 1'b0;
      table_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          load_done_reg <= 1'b0;
          if (load_start) begin
            state_reg       <= LOAD;
            idx_reg         <= '0;
            table_valid_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (wr_valid) begin
            idx_reg <= idx_reg + idx_t'(1);
            if (idx_reg == LAST_INDEX) begin
              state_reg     <= DONE;
              load_done_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg       <= IDLE;
          load_done_reg   <= 1'b0;
          table_valid_reg <= 1'b1;
        end
        default: begin
          state_reg     <= IDLE;
          load_done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign load_done   = load_done_reg;
  assign table_valid = table_valid_reg;

  act_lut_regfile #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH),
    .N  (ENTRIES)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_index     (idx_reg),
    .wr_data      (wr_data),
    .rd_address   (rd_address),
    .rd_base      (raw_base),
    .rd_next_data (raw_next)
  );

  // Hide partially written or stale contents until a full load has landed.
  assign rd_base      = table_valid_reg ? raw_base : '0;
  assign rd_next_data = table_valid_reg ? raw_next : '0;

endmodule : act_lut_loader

// File: tb/tb_act_lut_loader.sv
// Directed and randomized checks of act_lut_loader against a table model.
module tb_act_lut_loader;
  import act_lut_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  load_start = 1'b0;
  logic                  wr_valid = 1'b0;
  logic [DATA_WIDTH-1:0] wr_data = '0;
  logic                  wr_ready;
  logic                  busy;
  logic                  load_done;
  logic                  table_valid;
  logic [ADDR_WIDTH-1:0] rd_address = '0;
  logic [DATA_WIDTH-1:0] rd_base;
  logic [DATA_WIDTH-1:0] rd_next_data;

  int nvec = 0;
  int nerr = 0;

  // Reference model: the last completely loaded table and whether it is visible.
  logic [7:0] m_tbl [17];
  bit         m_valid = 1'b0;
  logic [7:0] cur_vals [17];

  act_lut_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .busy         (busy),
    .load_done    (load_done),
    .table_valid  (table_valid),
    .rd_address   (rd_address),
    .rd_base      (rd_base),
    .rd_next_data (rd_next_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input bit e_ready, input bit e_busy,
                             input bit e_done, input bit e_valid);
    chk({tag, "_wr_ready"}, {31'd0, wr_ready}, {31'd0, e_ready});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, "_load_done"}, {31'd0, load_done}, {31'd0, e_done});
    chk({tag, "_table_valid"}, {31'd0, table_valid}, {31'd0, e_valid});
  endtask

  // Sweep every segment address and compare both read ports with the model.
  task automatic check_reads(input string tag);
    for (int a = 0; a < 16; a++) begin
      logic [7:0] eb;
      logic [7:0] en;
      rd_address = 4'(a);
      @(negedge clk);
      eb = m_valid ? m_tbl[a] : 8'h00;
      en = m_valid ? m_tbl[a + 1] : 8'h00;
      chk($sformatf("%s_base[%0d]", tag, a), {24'd0, rd_base}, {24'd0, eb});
      chk($sformatf("%s_next[%0d]", tag, a), {24'd0, rd_next_data}, {24'd0, en});
      $display("read %s addr=%0d base=%0d next=%0d", tag, a,
               $signed(rd_base), $signed(rd_next_data));
    end
  endtask

  // Full load of cur_vals, with an optional stall and ignored load_start pokes.
  task automatic load_table(input string tag, input int stall_after, input int stall_len,
                            input bit poke_mid, input bit poke_done);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    m_valid = 1'b0;
    check_flags({tag, "_enter"}, 1'b1, 1'b1, 1'b0, 1'b0);
    rd_address = 4'($urandom_range(0, 15));
    @(negedge clk);
    chk({tag, "_hidden_base"}, {24'd0, rd_base}, 32'd0);
    chk({tag, "_hidden_next"}, {24'd0, rd_next_data}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = cur_vals[i];
      if (poke_mid && i == 5) load_start = 1'b1;
      step();
      load_start = 1'b0;
      $display("write %s idx=%0d data=%0d", tag, i, $signed(cur_vals[i]));
      if (i == stall_after) begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
        repeat (stall_len) step();
        check_flags({tag, "_stall"}, 1'b1, 1'b1, 1'b0, 1'b0);
      end
    end
    // One cycle after the final handshake: DONE, with wr_valid still high.
    check_flags({tag, "_done"}, 1'b0, 1'b1, 1'b1, 1'b0);
    wr_valid = 1'b0;
    if (poke_done) load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 17; i++) m_tbl[i] = cur_vals[i];
    m_valid = 1'b1;
    check_flags({tag, "_after"}, 1'b0, 1'b0, 1'b0, 1'b1);
    if (poke_done) begin
      step();
      check_flags({tag, "_no_restart"}, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic set_relu();
    int relu [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 16, 32, 48, 64, 80, 96, 112, 127};
    for (int i = 0; i < 17; i++) cur_vals[i] = 8'(relu[i]);
  endtask

  initial begin
    for (int i = 0; i < 17; i++) m_tbl[i] = 8'h00;

    // 1: reset held, then idle
    rst = 1'b0;
    repeat (3) step();
    check_flags("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rd_address = 4'd5;
    @(negedge clk);
    chk("idle_base5", {24'd0, rd_base}, 32'd0);
    chk("idle_next5", {24'd0, rd_next_data}, 32'd0);
    check_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: ReLU load, wr_valid held high throughout
    set_relu();
    load_table("relu", -1, 0, 1'b0, 1'b0);
    check_reads("relu");
    rd_address = 4'd10;
    @(negedge clk);
    chk("relu_a10_base", {24'd0, rd_base}, 32'd32);
    chk("relu_a10_next", {24'd0, rd_next_data}, 32'd48);
    rd_address = 4'd15;
    @(negedge clk);
    chk("relu_a15_base", {24'd0, rd_base}, 32'd112);
    chk("relu_a15_next", {24'd0, rd_next_data}, 32'd127);

    // 3: host stalls 4 cycles after entry 7, same final table
    load_table("stall", 7, 4, 1'b0, 1'b0);
    check_reads("stall");

    // 4: writes in IDLE are ignored; load_start ignored in LOAD and DONE
    wr_valid = 1'b1;
    wr_data  = 8'h80;
    repeat (3) step();
    check_flags("idle_wr", 1'b0, 1'b0, 1'b0, 1'b1);
    wr_valid = 1'b0;
    rd_address = 4'd0;
    @(negedge clk);
    chk("idle_wr_t0", {24'd0, rd_base}, 32'd0);
    load_table("poke", 3, 2, 1'b1, 1'b1);
    check_reads("poke");

    // 5: asynchronous reset part-way through a load
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      step();
    end
    wr_valid = 1'b0;
    rst = 1'b0;
    #1;
    m_valid = 1'b0;
    for (int i = 0; i < 17; i++) m_tbl[i] = 8'h00;
    check_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_base", {24'd0, rd_base}, 32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    check_flags("midrst_rel", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cur_vals[i] = 8'hFF;
    load_table("ones", -1, 0, 1'b0, 1'b0);
    check_reads("ones");

    // 6: reloads with random data and random stalls
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 17; i++) cur_vals[i] = 8'($urandom);
      load_table($sformatf("rnd%0d", r), int'($urandom_range(0, 15)),
                 int'($urandom_range(1, 5)), 1'($urandom), 1'($urandom));
      check_reads($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_act_lut_loader
